cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the single cache-to-AXI memory port between the instruction cache and the data cache. Sits between `i_cache`/`d_cache` and `axi_interface` in `mycpu`, replacing the combinational select mux. It does three things:
- registers each granted request and holds it stable until the memory side completes;
- routes the completion pulse back only to the owning cache;
- inserts one turnaround cycle between transactions so a stale strobe is never re-granted.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports (name, direction, width, meaning):
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `i_strobe` in 1: I-cache miss request (`m_fetch`).
- `i_addr` in ADDR_W: I-cache line/word address.
- `i_ready` out 1: I-side completion pulse.
- `i_rdata` out DATA_W: read data to I-cache.
- `d_strobe` in 1: D-cache request (`m_ld_st`).
- `d_rw` in 1: D-side direction; 1 = write.
- `d_addr` in ADDR_W: D-side address.
- `d_size` in 2: D-side transfer size.
- `d_sel` in 4: D-side byte strobes.
- `d_wdata` in DATA_W: D-side store data.
- `d_ready` out 1: D-side completion pulse.
- `d_rdata` out DATA_W: read data to D-cache.
- `mem_access` out 1: request valid to `axi_interface`.
- `mem_write` out 1: write transaction.
- `mem_a` out ADDR_W: address.
- `mem_size` out 2: size.
- `mem_sel` out 4: byte strobes.
- `mem_st_data` out DATA_W: store data.
- `mem_ready` in 1: transaction done (single-cycle pulse).
- `mem_data` in DATA_W: read data.
- `grant_d` out 1: the D-cache owns the port (for debug/perf).

## Operation
FSM states: IDLE, BUSY_I, BUSY_D, TURN.

- **IDLE:** `mem_access` = 0.
  - `d_strobe` = 1: capture the D request, go to BUSY_D.
  - Else `i_strobe` = 1: capture the I request, go to BUSY_I.
  - Neither: stay in IDLE.
  - Default priority: data over instruction, because a stalled MEM stage blocks the whole pipe.
- **Capture:** loads the `mem_a`, `mem_write`, `mem_size`, `mem_sel` and `mem_st_data` registers.
  - I-side capture forces `mem_write` = 0, `mem_size` = 2'b10 and `mem_sel` = 4'b1111.
  - D-side capture takes `d_rw`, `d_size`, `d_sel` and `d_wdata`.
- **BUSY_x:** `mem_access` = 1 and the captured fields are held constant.
  - Requester strobes and inputs are ignored.
  - On `mem_ready` = 1, go to TURN.
- **TURN:** `mem_access` = 0 for exactly one cycle, then go to IDLE.
  - Lets the owning cache drop its strobe after seeing ready.
- **Ready routing:** `i_ready` = `mem_ready` & (state == BUSY_I). `d_ready` = `mem_ready` & (state == BUSY_D).
- **Read data:** `i_rdata` = `d_rdata` = `mem_data`, combinational pass-through.
- **`grant_d`:** 1 in BUSY_D and in the following TURN; otherwise 0.
- **Strobe dropped while BUSY:** the transaction still completes and the ready pulse is still driven.
- **`mem_ready` outside BUSY:** ignored; neither ready output asserts.

## Timing
- **Reset:** state = IDLE; `mem_access`, `mem_write`, `grant_d`, `i_ready`, `d_ready` = 0; `mem_a`, `mem_st_data` = 0; `mem_size` = 0; `mem_sel` = 0.
- **Reset mid-transaction:** return to IDLE immediately and drop `mem_access` asynchronously. `axi_interface` shares `resetn`.
- **Arbitration latency:** strobe sampled at edge N, `mem_access` high from edge N onward (first cycle after the strobe is seen).
- **Ready latency:** ready outputs are combinational from `mem_ready`; zero added latency.
- **Minimum gap:** one TURN cycle between consecutive grants.
- **Simultaneous `i_strobe` and `d_strobe` in IDLE:** D wins. I waits, keeps its strobe high, and is granted after D's TURN if `d_strobe` is then low.
- **Back-to-back D requests:** can starve I indefinitely in the default build (accepted; the D side stalls the pipeline anyway).

## Configuration
- **`ARB_RR_EN` defined:** round-robin priority using a 1-bit `last_owner` register.
  - `last_owner` resets to I and updates on every grant.
  - On a tie in IDLE, the requester that did not win last time is granted.
  - A lone requester is always granted.
- **`ARB_RR_EN` undefined:** fixed D-over-I priority; no `last_owner` register is built.

## Test plan
- **Reset mid-transaction:** `resetn` = 0 while in BUSY_D -> `mem_access` = 0 immediately, and state is IDLE after release.
- **Lone I read:**
  - Stimulus: `i_strobe` = 1, `i_addr` = 0xBFC00000; `mem_ready` pulses 3 cycles later with `mem_data` = 0x24010001.
  - Required: `mem_access` high for 3 cycles with `mem_a` = 0xBFC00000, `mem_write` = 0, `mem_sel` = 4'hF.
  - Required: `i_ready` pulses once with `i_rdata` = 0x24010001; `d_ready` stays 0; one TURN cycle follows.
- **Simultaneous requests:**
  - Stimulus: `d_strobe` (write, `d_addr` = 0x800D0000, `d_sel` = 4'b0011, `d_wdata` = 0x1234) and `i_strobe` both high.
  - Required: D is granted first with `mem_write` = 1, `mem_sel` = 4'b0011, `mem_st_data` = 0x1234.
  - Required: I is granted after the TURN cycle.
- **Input change during BUSY_I:** change `i_addr` and raise `d_strobe` -> `mem_a` stays at the captured value and no ready is misrouted.
- **Stray completion:** `mem_ready` pulse in IDLE -> no ready output and no state change.
- **Round robin (`ARB_RR_EN` defined):** four consecutive simultaneous I/D requests -> grants alternate D, I, D, I (`last_owner` resets to I, so D goes first).

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared memory port between I-cache and D-cache; registers the granted request.
// Optional ARB_RR_EN: round-robin tie-break via last_owner (default: fixed D-over-I priority).
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_strobe,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_strobe,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [3:0]        d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_access,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_a,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_sel,
  output logic [DATA_W-1:0] mem_st_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, TURN} state_t;

  state_t state, state_nx;
  logic   grab_i, grab_d;
  logic   pick_d;

`ifdef ARB_RR_EN
  logic last_owner;  // 1 = D won the most recent grant

  always_comb pick_d = d_strobe & (~i_strobe | ~last_owner);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               last_owner <= 1'b0;
    else if (grab_i || grab_d) last_owner <= grab_d;
  end
`else
  always_comb pick_d = d_strobe;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grab_i   = 1'b0;
    grab_d   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          grab_d   = 1'b1;
          state_nx = BUSY_D;
        end else if (i_strobe) begin
          grab_i   = 1'b1;
          state_nx = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (mem_ready) state_nx = TURN;
      TURN:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_write   <= 1'b0;
      mem_a       <= '0;
      mem_size    <= '0;
      mem_sel     <= '0;
      mem_st_data <= '0;
      grant_d     <= 1'b0;
    end else begin
      if (grab_d) begin
        mem_write   <= d_rw;
        mem_a       <= d_addr;
        mem_size    <= d_size;
        mem_sel     <= d_sel;
        mem_st_data <= d_wdata;
      end else if (grab_i) begin
        mem_write   <= 1'b0;
        mem_a       <= i_addr;
        mem_size    <= 2'b10;
        mem_sel     <= 4'b1111;
      end
      // grant_d stays up through the TURN that follows a D transaction
      if (grab_d)             grant_d <= 1'b1;
      else if (state == TURN) grant_d <= 1'b0;
    end
  end

  assign mem_access = (state == BUSY_I) || (state == BUSY_D);
  assign i_ready    = mem_ready && (state == BUSY_I);
  assign d_ready    = mem_ready && (state == BUSY_D);
  assign i_rdata    = mem_data;
  assign d_rdata    = mem_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; tie-break expectations follow ARB_RR_EN.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_strobe, d_strobe, d_rw, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_data;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic        i_ready, d_ready, mem_access, mem_write, grant_d;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_st_data;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;

  int total = 0;
  int bad   = 0;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_strobe(d_strobe), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_sel(d_sel),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_access(mem_access), .mem_write(mem_write), .mem_a(mem_a), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  // advance to 2 time units after the next rising edge
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    resetn = 1'b0; i_strobe = 1'b1; d_strobe = 1'b1; mem_ready = 1'b1;
    #22;
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL rst_access got %b want 0", mem_access); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_write got %b want 0", mem_write); end
    total++; if (grant_d !== 1'b0) begin bad++; $display("FAIL rst_grant_d got %b want 0", grant_d); end
    total++; if ({i_ready, d_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got %b want 00", {i_ready, d_ready}); end
    total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rst_mem_a got %h want 0", mem_a); end
    total++; if (mem_st_data !== 32'h0) begin bad++; $display("FAIL rst_st_data got %h want 0", mem_st_data); end
    total++; if ({mem_size, mem_sel} !== 6'h00) begin bad++; $display("FAIL rst_size_sel got %h want 00", {mem_size, mem_sel}); end
    i_strobe = 1'b0; d_strobe = 1'b0; mem_ready = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_tie_sequence;
    logic [3:0] exp_d;
`ifdef ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    i_strobe = 1'b1; i_addr = 32'hBFC00100;
    d_strobe = 1'b1; d_rw = 1'b0; d_addr = 32'h80000100;
    for (int r = 0; r < 4; r++) begin
      cyc();
      total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL tie%0d_access got %b want 1", r, mem_access); end
      total++; if (grant_d !== exp_d[r]) begin bad++; $display("FAIL tie%0d_grant_d got %b want %b", r, grant_d, exp_d[r]); end
      mem_ready = 1'b1;
      #1;
      total++; if ({i_ready, d_ready} !== {~exp_d[r], exp_d[r]}) begin bad++; $display("FAIL tie%0d_ready got %b want %b", r, {i_ready, d_ready}, {~exp_d[r], exp_d[r]}); end
      cyc();
      mem_ready = 1'b0;
      total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL tie%0d_turn got %b want 0", r, mem_access); end
      cyc();
    end
    i_strobe = 1'b0; d_strobe = 1'b0;
    cyc();
  endtask

  task automatic test_lone_i_read;
    i_strobe = 1'b1; i_addr = 32'hBFC00000;
    cyc();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL lone_c1_access got %b want 1", mem_access); end
    total++; if (mem_a !== 32'hBFC00000) begin bad++; $display("FAIL lone_mem_a got %h want bfc00000", mem_a); end
    total++; if ({mem_write, mem_size, mem_sel} !== 7'b0_10_1111) begin bad++; $display("FAIL lone_fields got %b want 0101111", {mem_write, mem_size, mem_sel}); end
    total++; if (grant_d !== 1'b0) begin bad++; $display("FAIL lone_grant_d got %b want 0", grant_d); end
    cyc();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL lone_c2_access got %b want 1", mem_access); end
    cyc();
    mem_ready = 1'b1; mem_data = 32'h24010001;
    #1;
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL lone_c3_access got %b want 1", mem_access); end
    total++; if ({i_ready, d_ready} !== 2'b10) begin bad++; $display("FAIL lone_ready got %b want 10", {i_ready, d_ready}); end
    total++; if (i_rdata !== 32'h24010001) begin bad++; $display("FAIL lone_rdata got %h want 24010001", i_rdata); end
    cyc();
    mem_ready = 1'b0; i_strobe = 1'b0;
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL lone_turn got %b want 0", mem_access); end
    cyc();
    total++; if (mem_access !== 1'b0) begin bad++; $display("FAIL lone_idle got %b want 0", mem_access); end
  endtask

  task automatic test_simultaneous;
    i_strobe = 1'b1; i_addr = 32'hBFC00010;
    d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h800D0000; d_sel = 4'b0011; d_size = 2'b01; d_wdata = 32'h1234;
    cyc();
    total++; if (grant_d !== 1'b1) begin bad++; $display("FAIL sim_grant_d got %b want 1", grant_d); end
    total++; if (mem_a !== 32'h800D0000) begin bad++; $display("FAIL sim_mem_a got %h want 800d0000", mem_a); end
    total++; if ({mem_write, mem_size, mem_sel} !== 7'b1_01_0011) begin bad++; $display("FAIL sim_fields got %b want 1010011", {mem_write, mem_size, mem_sel}); end
    total++; if (mem_st_data !== 32'h1234) begin bad++; $display("FAIL sim_st_data got %h want 00001234", mem_st_data); end
    mem_ready = 1'b1; mem_data = 32'hCAFE0001;
    #1;
    total++; if ({i_ready, d_ready} !== 2'b01) begin bad++; $display("FAIL sim_ready got %b want 01", {i_ready, d_ready}); end
    total++; if (d_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL sim_rdata got %h want cafe0001", d_rdata); end
    cyc();
    mem_ready = 1'b0; d_strobe = 1'b0;
    total++; if ({mem_access, grant_d} !== 2'b01) begin bad++; $display("FAIL sim_turn got %b want 01", {mem_access, grant_d}); end
    cyc();
    total++; if ({mem_access, grant_d} !== 2'b00) begin bad++; $display("FAIL sim_idle got %b want 00", {mem_access, grant_d}); end
    cyc();
    total++; if ({mem_access, grant_d} !== 2'b10) begin bad++; $display("FAIL sim_i_grant got %b want 10", {mem_access, grant_d}); end
    total++; if (mem_a !== 32'hBFC00010) begin bad++; $display("FAIL sim_i_mem_a got %h want bfc00010", mem_a); end
  endtask

  // continues from the BUSY_I left by test_simultaneous
  task automatic test_input_change_busy_i;
    i_addr = 32'h12345678;
    d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h80000040; d_wdata = 32'h55AA55AA; d_sel = 4'hC; d_size = 2'b10;
    cyc();
    total++; if (mem_a !== 32'hBFC00010) begin bad++; $display("FAIL chg_mem_a got %h want bfc00010", mem_a); end
    total++; if ({mem_access, mem_write, grant_d} !== 3'b100) begin bad++; $display("FAIL chg_hold got %b want 100", {mem_access, mem_write, grant_d}); end
    mem_ready = 1'b1;
    #1;
    total++; if ({i_ready, d_ready} !== 2'b10) begin bad++; $display("FAIL chg_ready got %b want 10", {i_ready, d_ready}); end
    cyc();
    mem_ready = 1'b0; i_strobe = 1'b0;
    cyc();
    cyc();
    total++; if ({mem_access, grant_d} !== 2'b11) begin bad++; $display("FAIL chg_d_grant got %b want 11", {mem_access, grant_d}); end
    total++; if (mem_a !== 32'h80000040) begin bad++; $display("FAIL chg_d_mem_a got %h want 80000040", mem_a); end
    total++; if (mem_st_data !== 32'h55AA55AA) begin bad++; $display("FAIL chg_d_st_data got %h want 55aa55aa", mem_st_data); end
    mem_ready = 1'b1;
    #1;
    total++; if ({i_ready, d_ready} !== 2'b01) begin bad++; $display("FAIL chg_d_ready got %b want 01", {i_ready, d_ready}); end
    cyc();
    mem_ready = 1'b0; d_strobe = 1'b0;
    cyc();
  endtask

  task automatic test_stray_ready;
    mem_ready = 1'b1;
    #1;
    total++; if ({i_ready, d_ready, mem_access} !== 3'b000) begin bad++; $display("FAIL stray_out got %b want 000", {i_ready, d_ready, mem_access}); end
    cyc();
    mem_ready = 1'b0;
    total++; if ({mem_access, grant_d} !== 2'b00) begin bad++; $display("FAIL stray_after got %b want 00", {mem_access, grant_d}); end
    i_strobe = 1'b1; i_addr = 32'h00000100;
    cyc();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL stray_still_idle got %b want 1", mem_access); end
    mem_ready = 1'b1;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL stray_i_ready got %b want 1", i_ready); end
    cyc();
    mem_ready = 1'b0; i_strobe = 1'b0;
    cyc();
  endtask

  task automatic test_strobe_dropped;
    d_strobe = 1'b1; d_rw = 1'b0; d_addr = 32'h80001000;
    cyc();
    d_strobe = 1'b0;
    cyc();
    total++; if ({mem_access, grant_d} !== 2'b11) begin bad++; $display("FAIL drop_hold got %b want 11", {mem_access, grant_d}); end
    cyc();
    mem_ready = 1'b1;
    #1;
    total++; if ({i_ready, d_ready} !== 2'b01) begin bad++; $display("FAIL drop_ready got %b want 01", {i_ready, d_ready}); end
    cyc();
    mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid;
    d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h800D0100; d_wdata = 32'hFFFF0000;
    cyc();
    total++; if (mem_access !== 1'b1) begin bad++; $display("FAIL rmid_busy got %b want 1", mem_access); end
    resetn = 1'b0;
    #1;
    total++; if ({mem_access, grant_d, mem_write} !== 3'b000) begin bad++; $display("FAIL rmid_async got %b want 000", {mem_access, grant_d, mem_write}); end
    total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rmid_mem_a got %h want 0", mem_a); end
    d_strobe = 1'b0;
    cyc();
    resetn = 1'b1;
    i_strobe = 1'b1; i_addr = 32'h00000200;
    cyc();
    total++; if ({mem_access, grant_d} !== 2'b10) begin bad++; $display("FAIL rmid_idle_grant got %b want 10", {mem_access, grant_d}); end
    total++; if (mem_a !== 32'h00000200) begin bad++; $display("FAIL rmid_mem_a2 got %h want 00000200", mem_a); end
    mem_ready = 1'b1;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rmid_i_ready got %b want 1", i_ready); end
    cyc();
    mem_ready = 1'b0; i_strobe = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0; d_rw = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_data = '0; d_size = '0; d_sel = '0;
    test_reset();
    test_tie_sequence();
    test_lone_i_read();
    test_simultaneous();
    test_input_change_busy_i();
    test_stray_ready();
    test_strobe_dropped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
